// File: rtl/mem_bus_bridge.sv
// M-stage memory access unit: decodes the effective address into DM / timer / interrupt
// windows, drives the DM or device port, stalls multi-cycle accesses, returns raw load words.
module mem_bus_bridge #(
  parameter int unsigned DM_LAT  = 1,
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] DM_LO   = 32'h0000_0000,
  parameter logic [31:0] DM_HI   = 32'h0000_2FFF,
  parameter logic [31:0] TC1_LO  = 32'h0000_7F00,
  parameter logic [31:0] TC1_HI  = 32'h0000_7F0B,
  parameter logic [31:0] TC2_LO  = 32'h0000_7F10,
  parameter logic [31:0] TC2_HI  = 32'h0000_7F1B,
  parameter logic [31:0] INT_LO  = 32'h0000_7F20,
  parameter logic [31:0] INT_HI  = 32'h0000_7F23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic        dm_en,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        dev_req,
  output logic [1:0]  dev_sel,
  output logic        dev_we,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ack
);

  localparam int LW = (DM_LAT > 1) ? $clog2(DM_LAT) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, DM_WAIT, DEV_WAIT, DONE, ERR} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          we_q, we_d;
  logic [1:0]    sel_q, sel_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  // Single unsigned compare keeps both window ends inclusive, even when LO is 0.
  function automatic logic in_win(input logic [31:0] a, lo, hi);
    return (a - lo) <= (hi - lo);
  endfunction

  logic        dm_hit;
  logic [1:0]  sel_in;
  logic [3:0]  be;
  logic [31:0] lane_wdata;

  always_comb begin
    dm_hit = in_win(req_addr, DM_LO, DM_HI);
    sel_in = 2'b00;
    if (in_win(req_addr, TC1_LO, TC1_HI))      sel_in = 2'b01;
    else if (in_win(req_addr, TC2_LO, TC2_HI)) sel_in = 2'b10;
    else if (in_win(req_addr, INT_LO, INT_HI)) sel_in = 2'b11;
    be         = 4'b0000;
    lane_wdata = req_wdata;
    case (req_size)
      2'b00: be = 4'b1111;
      2'b01: begin
        be         = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be         = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    to_cnt_d  = to_cnt_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    stall       = 1'b0;
    rdata_valid = 1'b0;
    bus_err     = 1'b0;
    dm_en       = 1'b0;
    dm_we       = 4'b0000;
    dm_addr     = 32'h0;
    dm_wdata    = 32'h0;
    dev_req     = 1'b0;
    dev_sel     = 2'b00;
    dev_we      = 1'b0;
    dev_addr    = 32'h0;
    dev_wdata   = 32'h0;
    case (state_q)
      IDLE: if (req_valid) begin
        stall   = 1'b1;
        we_d    = req_we;
        sel_d   = sel_in;
        addr_d  = {req_addr[31:2], 2'b00};
        wdata_d = req_wdata;
        if (dm_hit) begin
          dm_en     = 1'b1;
          dm_we     = req_we ? be : 4'b0000;
          dm_addr   = {req_addr[31:2], 2'b00};
          dm_wdata  = lane_wdata;
          lat_cnt_d = LW'(DM_LAT - 1);
          state_d   = DM_WAIT;
        end else if (sel_in != 2'b00) begin
          to_cnt_d = '0;
          state_d  = DEV_WAIT;
        end else begin
          state_d = ERR;
        end
      end
      DM_WAIT: begin
        stall = 1'b1;
        if (lat_cnt_q == '0) begin
          if (!we_q) rdata_d = dm_rdata;
          state_d = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - LW'(1);
        end
      end
      DEV_WAIT: begin
        stall     = 1'b1;
        dev_req   = 1'b1;
        dev_sel   = sel_q;
        dev_we    = we_q;
        dev_addr  = addr_q;
        dev_wdata = wdata_q;
        // An ack on the final allowed cycle still wins over the timeout.
        if (dev_ack) begin
          if (!we_q) rdata_d = dev_rdata;
          state_d = DONE;
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      DONE: begin
        rdata_valid = !we_q;
        state_d     = IDLE;
      end
      ERR: begin
        bus_err = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Combinational strobes must also vanish the moment reset is asserted.
    if (!reset) begin
      stall = 1'b0;
      dm_en = 1'b0;
      dm_we = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      to_cnt_q  <= '0;
      rdata_q   <= 32'h0;
      we_q      <= 1'b0;
      sel_q     <= 2'b00;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      to_cnt_q  <= to_cnt_d;
      rdata_q   <= rdata_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
